// File: rtl/tap_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tap_sequencer_pkg
// Description : Shared filter-datapath package. Holds the sequencer state
//               encoding and a constant ceil-log2 helper used to size
//               pointers and tap indices in the filter blocks.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package tap_sequencer_pkg;

   // Sequencer state: IDLE accepts a sample, READ plays the history back.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } tap_state_t;

   // Default geometry shared by the filter blocks.
   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_TAPS       = 8;

   // ceil(log2(value)); returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tap_history_ram.sv
`default_nettype none
// ============================================================================
// Module      : tap_history_ram
// Description : TAPS x DATA_WIDTH register array holding the sample history.
//               One synchronous write port, one asynchronous read port and a
//               synchronous clear that zeros every slot.
// Ports       : clk    - system clock
//               rst    - asynchronous reset, active low; zeros every slot
//               clr    - synchronous clear of every slot (beats a write)
//               we     - write enable
//               waddr  - write slot
//               wdata  - write data
//               raddr  - read slot
//               rdata  - contents of slot raddr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module tap_history_ram
   import tap_sequencer_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int TAPS       = DEFAULT_TAPS,
   localparam int ADDR_W     = clog2(TAPS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] slot [TAPS];

   // One register per slot; each decodes its own write select.
   for (genvar i = 0; i < TAPS; i++) begin : g_slot
      logic [DATA_WIDTH-1:0] q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            q <= '0;
         end else if (clr) begin
            q <= '0;
         end else if (we && (waddr == ADDR_W'(i))) begin
            q <= wdata;
         end
      end

      assign slot[i] = q;
   end

   // TAPS is a power of two, so every raddr value selects a real slot.
   assign rdata = slot[raddr];

endmodule
`default_nettype wire

// File: rtl/tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tap_sequencer
// Description : Receiving end of the filter sample path. Each accepted sample
//               is written into a circular TAPS-deep history, then the whole
//               history is played back one tap per cycle, newest first, to a
//               time-multiplexed MAC stage.
// Ports       : clk         - system clock, rising edge
//               rst         - asynchronous reset, active low
//               clr         - synchronous clear of history and state
//               in_valid    - input sample offered
//               in_ready    - block can accept a sample (IDLE only)
//               in_data     - input sample
//               out_valid   - a tap is presented on out_data
//               out_ready   - downstream accepts the presented tap
//               out_data    - history sample for tap out_tap_idx
//               out_tap_idx - tap number, 0 is the newest sample
//               out_last    - high with the final tap (TAPS-1)
//               busy        - high while playing back the history
// Revision    : 1.0 - initial release
// ============================================================================
module tap_sequencer
   import tap_sequencer_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int TAPS       = DEFAULT_TAPS,
   localparam int ADDR_W     = clog2(TAPS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_W-1:0]     out_tap_idx,
   output logic                  out_last,
   output logic                  busy
);

   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   tap_state_t        state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] newest;
   logic [ADDR_W-1:0] tap_cnt;

   logic              accept;
   logic              advance;
   logic [ADDR_W-1:0] rd_addr;

   // in_ready is a registered flag that is only high in IDLE, so this is the
   // complete acceptance condition. clr wins over the handshake.
   assign accept  = in_valid && in_ready && !clr;
   assign advance = out_valid && out_ready;

   // Walking backwards from the newest slot; the ADDR_W-bit subtraction
   // wraps modulo TAPS, covering newest at slot 0 and at slot TAPS-1.
   assign rd_addr = newest - tap_cnt;

   assign out_tap_idx = tap_cnt;

   tap_history_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAPS       (TAPS)
   ) u_history (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_addr),
      .rdata (out_data)
   );

   // Control FSM. All handshake outputs are registered alongside the state
   // so they never depend combinationally on the inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         newest    <= '0;
         tap_cnt   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else if (clr) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         newest    <= '0;
         tap_cnt   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state     <= ST_READ;
                  newest    <= wr_ptr;
                  wr_ptr    <= wr_ptr + ONE;
                  tap_cnt   <= '0;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;  // TAPS >= 2, tap 0 is never the last
                  busy      <= 1'b1;
               end
            end

            ST_READ: begin
               if (advance) begin
                  if (tap_cnt == LAST_TAP) begin
                     state     <= ST_IDLE;
                     tap_cnt   <= '0;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     tap_cnt  <= tap_cnt + ONE;
                     out_last <= ((tap_cnt + ONE) == LAST_TAP);
                  end
               end
            end

            default: begin
               state     <= ST_IDLE;
               tap_cnt   <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_sequencer
// Description : Self-checking bench for tap_sequencer (TAPS=4, 8-bit data).
//               A shift-register history model predicts every output on
//               every cycle; directed bursts pin the model with literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_sequencer;

   localparam int DW   = 8;
   localparam int TAPS = 4;
   localparam int AW   = 2;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          clr       = 1'b0;
   logic          in_valid  = 1'b0;
   logic [DW-1:0] in_data   = '0;
   logic          out_ready = 1'b1;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_tap_idx;
   logic          out_last;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tap_sequencer #(
      .DATA_WIDTH (DW),
      .TAPS       (TAPS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_tap_idx (out_tap_idx),
      .out_last    (out_last),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: hist[0] is the newest sample, hist[j] the j-th older
   // one. A burst is simply "present hist[k] for k = 0..TAPS-1".
   // ------------------------------------------------------------------
   logic [DW-1:0] hist [TAPS];
   bit            m_busy;
   int            m_k;
   int            accepts = 0;

   task automatic model_reset();
      for (int j = 0; j < TAPS; j++) hist[j] = '0;
      m_busy = 1'b0;
      m_k    = 0;
   endtask

   always @(posedge clk) begin
      if (!rst || clr) begin
         model_reset();
      end else if (!m_busy) begin
         if (in_valid) begin
            for (int j = TAPS - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = in_data;
            m_busy  = 1'b1;
            m_k     = 0;
            accepts++;
         end
      end else if (out_ready) begin
         if (m_k == TAPS - 1) m_busy = 1'b0;
         else                 m_k    = m_k + 1;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst) model_reset();
      chk("in_ready",  32'(in_ready),  32'(!m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_busy));
      chk("busy",      32'(busy),      32'(m_busy));
      if (m_busy) begin
         chk("out_data",    32'(out_data),    32'(hist[m_k]));
         chk("out_tap_idx", 32'(out_tap_idx), 32'(m_k));
         chk("out_last",    32'(out_last),    32'(m_k == TAPS - 1));
      end
   end

   // ------------------------------------------------------------------
   // Directed helpers
   // ------------------------------------------------------------------
   task automatic send(input logic [DW-1:0] d);
      int n;
      n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Expects out_ready high and to be called right after send().
   task automatic burst(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                        input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                        input string tag);
      logic [DW-1:0] exp [4];
      exp = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("%s_valid%0d", tag, i), 32'(out_valid),   32'd1);
         chk($sformatf("%s_idx%0d",   tag, i), 32'(out_tap_idx), 32'(i));
         chk($sformatf("%s_last%0d",  tag, i), 32'(out_last),    32'(i == 3));
         chk($sformatf("%s_data%0d",  tag, i), 32'(out_data),    32'(exp[i]));
      end
      // One cycle after out_last the block is back in IDLE.
      @(negedge clk);
      chk({tag, "_end_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_end_ready"}, 32'(in_ready),  32'd1);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int start;
      int cyc;
      model_reset();

      // Power-on reset.
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // 1. Reset mid-run, then a lone sample on an empty history.
      send(8'hC3);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t1_rst_in_ready",  32'(in_ready),  32'd1);
      chk("t1_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t1_rst_busy",      32'(busy),      32'd0);
      @(posedge clk); #1 rst = 1'b1;
      send(8'h11);
      burst(8'h11, 8'h00, 8'h00, 8'h00, "t1");

      // 2. Normal sequence with out_ready high; history wraps past slot 3.
      send(8'h11);
      send(8'h22);
      send(8'h33);
      send(8'h44);
      send(8'h55);
      burst(8'h55, 8'h44, 8'h33, 8'h22, "t2");

      // 3. Backpressure at tap 1 with a sample offered during READ.
      send(8'hA5);
      @(negedge clk);
      chk("t3_tap0_idx",  32'(out_tap_idx), 32'd0);
      chk("t3_tap0_data", 32'(out_data),    32'hA5);
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hEE;
      repeat (3) begin
         @(negedge clk);
         chk("t3_hold_idx",   32'(out_tap_idx), 32'd1);
         chk("t3_hold_data",  32'(out_data),    32'h55);
         chk("t3_hold_last",  32'(out_last),    32'd0);
         chk("t3_hold_ready", 32'(in_ready),    32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("t3_resume_idx", 32'(out_tap_idx), 32'(i));
         chk("t3_resume_data", 32'(out_data),
             32'((i == 1) ? 8'h55 : (i == 2) ? 8'h44 : 8'h33));
      end
      @(negedge clk);
      chk("t3_end_valid", 32'(out_valid), 32'd0);

      // 4. clr together with an offered sample.
      @(posedge clk); #1;
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h99;
      @(posedge clk); #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("t4_clr_in_ready",  32'(in_ready),  32'd1);
      chk("t4_clr_out_valid", 32'(out_valid), 32'd0);
      send(8'h01);
      burst(8'h01, 8'h00, 8'h00, 8'h00, "t4");

      // 5. Asynchronous reset at tap 2.
      send(8'h33);
      repeat (3) @(negedge clk);
      chk("t5_at_tap2", 32'(out_tap_idx), 32'd2);
      #2 rst = 1'b0;
      #1;
      chk("t5_async_out_valid", 32'(out_valid), 32'd0);
      chk("t5_async_busy",      32'(busy),      32'd0);
      chk("t5_async_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk); #1 rst = 1'b1;
      send(8'h7F);
      burst(8'h7F, 8'h00, 8'h00, 8'h00, "t5");

      // 6. Random stream under random backpressure and rare clears.
      start = accepts;
      cyc   = 0;
      while ((accepts - start) < 1000 && cyc < 40000) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         clr       = ($urandom_range(0, 299) == 0);
         cyc++;
      end
      chk("t6_progress", 32'((accepts - start) >= 1000), 32'd1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
